key_cmd_sched: RTL
==================

Name: key_cmd_sched

Overview:
- Multi-key front-panel scheduler for the cartoonifier board.
- Takes NUM_KEYS raw active-high key levels and synchronises and debounces each one.
- Turns debounced rising edges (new presses) into pending requests and arbitrates them by fixed priority onto one valid/ready command channel.
- Keeps the filter-mode register stepped by the two mode keys. The pipeline control logic consumes the command channel and oMode.

Parameters:
- NUM_KEYS, 4: number of key inputs; must be >= 2.
- DEB_CYCLES, 4: consecutive synchronised samples that must disagree with the debounced level before it flips; must be >= 1.
- MODE_COUNT, 4: number of filter modes; must be >= 2.
- REPEAT_CYCLES, 1000: auto-repeat period in cycles; used only with the optional feature.

Ports:
- iCLK, in, 1: system clock.
- iRST, in, 1: synchronous, active-high reset.
- iKey, in, NUM_KEYS: raw key levels, active high, asynchronous to iCLK.
- iCmdReady, in, 1: consumer accepts the command this cycle.
- oCmdValid, out, 1: command present.
- oCmdKey, out, $clog2(NUM_KEYS): index of the key that issued the command.
- oMode, out, $clog2(MODE_COUNT): current filter mode.
- oKeyState, out, NUM_KEYS: debounced key levels.
- oDropCnt, out, 8: saturating count of presses lost because a request was already pending.

Behaviour:
- Reset: one clock; synchronous, active high on iRST. All outputs go to 0. Synchronisers, debounced levels, counters and pending bits clear. Reset overrides all other activity in that cycle.
- Synchroniser: 2 flops per key.
- Debounce counter: counts cycles in which the synchronised level differs from the debounced level. It clears whenever they match. When it equals DEB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- Press event: a debounced 0->1 flip sets pending[k] on that same edge.
- Latency: iKey held high from sampling edge 1 -> debounced flip and pending set at edge DEB_CYCLES+2 -> oCmdValid high after edge DEB_CYCLES+3, with the output stage idle.
- Output stage: a registered valid/key pair.
  - When idle, or on an accepting edge (oCmdValid & iCmdReady), it loads the lowest-index pending bit, excluding the bit just accepted.
  - oCmdValid stays high only if such a bit exists.
  - While oCmdValid is high and iCmdReady is low, oCmdKey is frozen; no re-arbitration.
  - Back-to-back commands on consecutive cycles are allowed.
- Pending clear: pending[k] clears on the edge its command is accepted.
  - If a new press of key k lands on that same edge, pending[k] stays set (set wins).
- Drop: a press of key k while pending[k] is already set, other than on its accept edge, increments oDropCnt. The counter saturates at 255.
- Mode update, on acceptance only:
  - Key 0 steps oMode up; MODE_COUNT-1 wraps to 0.
  - Key 1 steps oMode down; 0 wraps to MODE_COUNT-1.
  - Keys >= 2 do not change oMode.
- Release: debounced 1->0 flips update oKeyState only; they generate no command.
- Reset while a key is held: the debounced level is 0 after reset, so the held key is seen as a new press DEB_CYCLES+2 edges after reset deasserts.

Optional Feature:
- Macro: KEY_SCHED_AUTOREPEAT_EN.
- Defined: each key has a hold counter that starts at the press event and counts while the debounced level stays 1. Every REPEAT_CYCLES cycles it generates a press event, with the same pending/drop rules as a real press. The counter clears on release or reset.
- Undefined: no hold counters; only debounced rising edges generate press events. REPEAT_CYCLES is ignored.

Decomposition:
- Package key_sched_pkg holds:
  - KEY_MODE_NEXT=0 and KEY_MODE_PREV=1;
  - DROP_CNT_W=8;
  - index and mode width helpers.
- Sub-module key_debounce, instantiated once per key. It contains the 2-flop synchroniser, the debounce counter and the debounced level, and outputs a rise pulse.
- The top level holds the pending register, priority select, output register, mode register, drop counter and optional repeat logic.

Test Plan (DEB_CYCLES=4, NUM_KEYS=4, MODE_COUNT=4):
- Glitch: iKey[2] high for 3 cycles, then low -> oKeyState stays 0, oCmdValid never asserts.
- Clean press: iKey[2] held 20 cycles, iCmdReady=1 -> oCmdValid high after edge 7, oCmdKey=2, for exactly 1 cycle; oMode stays 0.
- Simultaneous press: iKey[3] and iKey[1] rise together, iCmdReady=0 for 10 cycles -> oCmdKey=1 held stable. Raise iCmdReady -> key 1 accepted (oMode=3), then key 3 on the very next cycle, then oCmdValid=0.
- Mode wrap: four clean presses of key 0, ready=1 -> oMode goes 1,2,3,0. One press of key 1 -> oMode=3.
- Drop: iCmdReady=0, three clean presses of key 2 -> oDropCnt=2. Raise ready -> exactly one key-2 command.
- Reset mid-command: iRST pulsed while oCmdValid=1 -> all outputs 0 after that edge. With iKey[0] still held, a new command appears DEB_CYCLES+3 edges after iRST drops.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared constants and width helpers for the key command scheduler.
package key_sched_pkg;

  // Keys with a fixed meaning for the filter-mode register
  localparam int KEY_MODE_NEXT = 0;
  localparam int KEY_MODE_PREV = 1;

  // Width of the lost-press counter
  localparam int DROP_CNT_W = 8;

  // Bits needed to index n items (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a filter-mode number for n modes
  function automatic int mode_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser and debounce filter; pulses oRise on the
// cycle the debounced level flips from 0 to 1.
module key_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iKey,
  output logic oLevel,
  output logic oRise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count disagreeing samples; flip the debounced level once enough accumulate
  always_comb begin
    sync1_d = iKey;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    oRise   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
        oRise   = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oLevel = level_q;

endmodule

// File: rtl/key_cmd_sched.sv
// Front-panel key scheduler: debounced presses become pending requests,
// arbitrated lowest-index-first onto a registered valid/ready command channel.
// Also keeps the filter-mode register and a saturating lost-press counter.
// Optional auto-repeat while a key is held: define KEY_SCHED_AUTOREPEAT_EN.
module key_cmd_sched
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int MODE_COUNT    = 4,
  parameter int REPEAT_CYCLES = 1000
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [NUM_KEYS-1:0]         iKey,
  input  logic                        iCmdReady,
  output logic                        oCmdValid,
  output logic [idx_w(NUM_KEYS)-1:0]  oCmdKey,
  output logic [mode_w(MODE_COUNT)-1:0] oMode,
  output logic [NUM_KEYS-1:0]         oKeyState,
  output logic [DROP_CNT_W-1:0]       oDropCnt
);

  localparam int KW = idx_w(NUM_KEYS);
  localparam int MW = mode_w(MODE_COUNT);

  // Reject configurations the scheduler cannot support
  if (NUM_KEYS < 2 || DEB_CYCLES < 1 || MODE_COUNT < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("key_cmd_sched: illegal parameter set");
  end

  logic [NUM_KEYS-1:0]   level, rise, rep, press;
  logic [NUM_KEYS-1:0]   pend_q, pend_d;
  logic [NUM_KEYS-1:0]   acc_mask, cand, drop_ev;
  logic                  acc;
  logic                  vld_q, vld_d;
  logic [KW-1:0]         key_q, key_d, pick;
  logic                  pick_ok;
  logic [MW-1:0]         mode_q, mode_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iKey  (iKey[k]),
      .oLevel(level[k]),
      .oRise (rise[k])
    );
  end

`ifdef KEY_SCHED_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] hold_q [NUM_KEYS];
  logic [RW-1:0] hold_d [NUM_KEYS];

  // Hold counters restart on each press and emit a repeat every REPEAT_CYCLES
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      hold_d[k] = '0;
      rep[k]    = 1'b0;
      if (!rise[k] && level[k]) begin
        if (hold_q[k] == RW'(REPEAT_CYCLES - 1)) begin
          rep[k] = 1'b1;
        end else begin
          hold_d[k] = hold_q[k] + 1'b1;
        end
      end
    end
  end

  // Hold counter registers
  always_ff @(posedge iCLK) begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (iRST) hold_q[k] <= '0;
      else      hold_q[k] <= hold_d[k];
    end
  end
`else
  // Without auto-repeat only real debounced presses create events
  always_comb begin
    rep = '0;
  end
`endif

  // Pending bits, priority select, output register, mode and drop counter
  always_comb begin
    press    = rise | rep;
    acc      = vld_q & iCmdReady;
    acc_mask = '0;
    if (acc) acc_mask[key_q] = 1'b1;
    cand     = pend_q & ~acc_mask;

    // Lowest-index candidate wins
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        pick    = KW'(k);
        pick_ok = 1'b1;
      end
    end

    // Output pair is frozen while a command waits for ready
    vld_d = vld_q;
    key_d = key_q;
    if (!vld_q || acc) begin
      vld_d = pick_ok;
      key_d = pick;
    end

    // A press landing on its own accept edge re-arms the bit
    pend_d = cand | press;

    drop_ev = press & pend_q & ~acc_mask;
    drop_d  = drop_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (drop_ev[k] && (drop_d != {DROP_CNT_W{1'b1}})) drop_d = drop_d + 1'b1;
    end

    mode_d = mode_q;
    if (acc) begin
      if (key_q == KW'(KEY_MODE_NEXT)) begin
        mode_d = (mode_q == MW'(MODE_COUNT - 1)) ? '0 : mode_q + 1'b1;
      end else if (key_q == KW'(KEY_MODE_PREV)) begin
        mode_d = (mode_q == '0) ? MW'(MODE_COUNT - 1) : mode_q - 1'b1;
      end
    end
  end

  // Scheduler state registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pend_q <= '0;
      vld_q  <= 1'b0;
      key_q  <= '0;
      mode_q <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      key_q  <= key_d;
      mode_q <= mode_d;
      drop_q <= drop_d;
    end
  end

  assign oCmdValid = vld_q;
  assign oCmdKey   = key_q;
  assign oMode     = mode_q;
  assign oKeyState = level;
  assign oDropCnt  = drop_q;

endmodule
